// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: 16 micro-rotations, one per clock, with
// saturated x/y results held until the next completed request.

module cordic_shift #(
  parameter int width  = 18,
  parameter int stages = 4
) (
  input  logic signed [width-1:0]  din,
  input  logic        [stages-1:0] shift,
  output logic signed [width-1:0]  dout
);
  assign dout = din >>> shift;
endmodule

module cordic_rotator #(
  parameter int no_bits = 16,
  parameter int stages  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [no_bits-1:0] x0,
  input  logic signed [no_bits-1:0] y0,
  input  logic signed [no_bits-1:0] z0,
  output logic                      busy,
  output logic                      done,
  output logic signed [no_bits-1:0] x_out,
  output logic signed [no_bits-1:0] y_out,
  output logic signed [no_bits-1:0] z_out,
  output logic [1:0]                state_dbg
);
  // Two guard bits keep x/y from wrapping: |x|,|y| grow by at most K*sqrt(2).
  localparam int ext = no_bits + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                  state, state_next;
  logic signed [ext-1:0]   x, y, z;
  logic signed [ext-1:0]   x_sh, y_sh, x_next, y_next, z_next, atan_ext;
  logic        [stages-1:0] i;
  logic        [no_bits-1:0] atan;
  logic                    load;

  cordic_shift #(.width(ext), .stages(stages)) u_shift_x (.din(x), .shift(i), .dout(x_sh));
  cordic_shift #(.width(ext), .stages(stages)) u_shift_y (.din(y), .shift(i), .dout(y_sh));

  always_comb begin
    atan = '0;
    case (i)
      4'd0:  atan = 16'd6434;
      4'd1:  atan = 16'd3798;
      4'd2:  atan = 16'd2007;
      4'd3:  atan = 16'd1019;
      4'd4:  atan = 16'd511;
      4'd5:  atan = 16'd256;
      4'd6:  atan = 16'd128;
      4'd7:  atan = 16'd64;
      4'd8:  atan = 16'd32;
      4'd9:  atan = 16'd16;
      4'd10: atan = 16'd8;
      4'd11: atan = 16'd4;
      4'd12: atan = 16'd2;
      4'd13: atan = 16'd1;
      default: atan = 16'd0;
    endcase
  end

  assign atan_ext = $signed({2'b00, atan});

  // Rotate toward z = 0: positive residual angle means rotate counter-clockwise.
  always_comb begin
    if (!z[ext-1]) begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - atan_ext;
    end else begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + atan_ext;
    end
  end

  function automatic logic signed [no_bits-1:0] sat(input logic signed [ext-1:0] v);
    if (v[ext-1:no_bits-1] == '0 || v[ext-1:no_bits-1] == '1)
      sat = v[no_bits-1:0];
    else if (v[ext-1])
      sat = {1'b1, {(no_bits-1){1'b0}}};
    else
      sat = {1'b0, {(no_bits-1){1'b1}}};
  endfunction

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RUN:     if (i == '1) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      i     <= '0;
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        x <= {{2{x0[no_bits-1]}}, x0};
        y <= {{2{y0[no_bits-1]}}, y0};
        z <= {{2{z0[no_bits-1]}}, z0};
        i <= '0;
      end else if (state == RUN) begin
        x <= x_next;
        y <= y_next;
        z <= z_next;
        i <= i + 1'b1;
        if (i == '1) begin
          x_out <= sat(x_next);
          y_out <= sat(y_next);
          z_out <= z_next[no_bits-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_cordic_rotator.sv
// Bench for cordic_rotator: cycle-level reference built from a countdown and
// a plain integer CORDIC, checked every cycle, plus directed scenarios.

module tb_cordic_rotator;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic signed [15:0] x0 = '0, y0 = '0, z0 = '0;
  logic               busy, done;
  logic signed [15:0] x_out, y_out, z_out;
  logic [1:0]         state_dbg;

  int vectors = 0;
  int miscompares = 0;

  int atan_tab[16] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0, 0};

  always #5 clk = ~clk;

  cordic_rotator #(.no_bits(16), .stages(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .z0(z0),
    .busy(busy), .done(done),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .state_dbg(state_dbg)
  );

  function automatic void cordic_ref(input int xi, input int yi, input int zi,
                                     output logic [15:0] xo, output logic [15:0] yo,
                                     output logic [15:0] zo);
    longint x, y, z, xn;
    x = xi; y = yi; z = zi;
    for (int k = 0; k < 16; k++) begin
      if (z >= 0) begin
        xn = x - (y >>> k); y = y + (x >>> k); z = z - atan_tab[k];
      end else begin
        xn = x + (y >>> k); y = y - (x >>> k); z = z + atan_tab[k];
      end
      x = xn;
    end
    if (x > 32767) xo = 16'h7fff; else if (x < -32768) xo = 16'h8000; else xo = x[15:0];
    if (y > 32767) yo = 16'h7fff; else if (y < -32768) yo = 16'h8000; else yo = y[15:0];
    zo = z[15:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, $signed(act), act,
               $signed(exp), exp);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    vectors++;
    if (v < lo || v > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected in [%0d,%0d]", name, v, lo, hi);
    end
  endtask

  // Reference: a request occupies 16 cycles, then results appear with a one-cycle done.
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_x = '0, m_y = '0, m_z = '0, p_x = '0, p_y = '0, p_z = '0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_done = 1'b0; m_x = '0; m_y = '0; m_z = '0; m_valid = 1'b1;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1; m_x = p_x; m_y = p_y; m_z = p_z;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        cordic_ref(x0, y0, z0, p_x, p_y, p_z);
        m_cnt = 16;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", {15'd0, busy}, {15'd0, (m_cnt > 0)});
      check("done", {15'd0, done}, {15'd0, m_done});
      check("x_out", x_out, m_x);
      check("y_out", y_out, m_y);
      check("z_out", z_out, m_z);
    end
  end

  task automatic rand_inputs();
    int t;
    x0 = $urandom; y0 = $urandom;
    t = int'($urandom_range(0, 25736)) - 12868;
    z0 = t[15:0];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      rand_inputs();
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic request(input int xa, input int ya, input int za, output int lat);
    @(negedge clk);
    start = 1'b1; x0 = xa[15:0]; y0 = ya[15:0]; z0 = za[15:0];
    @(negedge clk);
    start = 1'b0;
    rand_inputs();
    wait_done(lat);
  endtask

  int lat, pulses;
  logic [15:0] ex, ey, ez;

  initial begin
    // Pin the reference model against hand-derived expectations.
    cordic_ref(9949, 0, 0, ex, ey, ez);
    check_range("model_unit_x", $signed(ex), 16376, 16392);
    check_range("model_unit_y", $signed(ey), -8, 8);
    check_range("model_unit_z", $signed(ez), -4, 4);
    cordic_ref(9949, 0, 6434, ex, ey, ez);
    check_range("model_p45_x", $signed(ex), 11577, 11593);
    check_range("model_p45_y", $signed(ey), 11577, 11593);
    cordic_ref(9949, 0, -6434, ex, ey, ez);
    check_range("model_m45_y", $signed(ey), -11593, -11577);
    cordic_ref(32767, 32767, 0, ex, ey, ez);
    check("model_sat_x", ex, 16'h7fff);
    check("model_sat_y", ey, 16'h7fff);
    cordic_ref(-32768, 0, 0, ex, ey, ez);
    check("model_sat_neg", ex, 16'h8000);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(20);

    request(9949, 0, 0, lat);
    check_range("unit_latency", lat, 16, 16);
    check_range("unit_x", $signed(x_out), 16376, 16392);
    check_range("unit_y", $signed(y_out), -8, 8);
    check_range("unit_z", $signed(z_out), -4, 4);
    idle(2);

    request(9949, 0, 6434, lat);
    check_range("p45_x", $signed(x_out), 11577, 11593);
    check_range("p45_y", $signed(y_out), 11577, 11593);
    request(9949, 0, -6434, lat);
    check_range("m45_x", $signed(x_out), 11577, 11593);
    check_range("m45_y", $signed(y_out), -11593, -11577);

    request(32767, 32767, 0, lat);
    check("sat_x", x_out, 16'h7fff);
    check("sat_y", y_out, 16'h7fff);
    request(-32768, 0, 0, lat);
    check("sat_neg_x", x_out, 16'h8000);
    idle(3);

    // Second start while busy must be ignored.
    @(negedge clk);
    start = 1'b1; x0 = 16'sd5000; y0 = -16'sd3000; z0 = 16'sd4000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; x0 = -16'sd7000; y0 = 16'sd1234; z0 = -16'sd9000;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_range("ignored_b_pulses", pulses, 1, 1);
    cordic_ref(5000, -3000, 4000, ex, ey, ez);
    check("ignored_b_x", x_out, ex);
    check("ignored_b_y", y_out, ey);

    // Start held high through done: the held request is accepted in the done cycle.
    @(negedge clk);
    start = 1'b1; x0 = 16'sd2000; y0 = 16'sd2000; z0 = 16'sd1000;
    @(negedge clk);
    x0 = -16'sd4321; y0 = 16'sd8765; z0 = 16'sd12000;
    wait_done(lat);
    check_range("held_first_latency", lat, 16, 16);
    @(negedge clk);
    start = 1'b0;
    check("held_busy", {15'd0, busy}, 16'd1);
    rand_inputs();
    wait_done(lat);
    check_range("held_second_latency", lat, 16, 16);
    cordic_ref(-4321, 8765, 12000, ex, ey, ez);
    check("held_c_x", x_out, ex);
    idle(2);

    // Reset partway through a run.
    @(negedge clk);
    start = 1'b1; x0 = 16'sd9949; y0 = 16'sd100; z0 = 16'sd3000;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_x", x_out, 16'd0);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_range("midrst_pulses", pulses, 0, 0);
    request(-9949, 500, -12000, lat);
    check_range("after_rst_latency", lat, 16, 16);

    // Random traffic with occasional resets and extreme vectors.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 3) == 0);
      rand_inputs();
      if ($urandom_range(0, 7) == 0) x0 = $urandom_range(0, 1) ? 16'h8000 : 16'h7fff;
      if ($urandom_range(0, 7) == 0) y0 = $urandom_range(0, 1) ? 16'h8000 : 16'h7fff;
    end
    @(negedge clk);
    rst = 1'b0;
    idle(25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
